uart_rx: RTL
============

Name: uart_rx

Overview:
Serial receiver for the UART link; the counterpart stage downstream of the transmitter on the same line.
- Frame format: 1 start bit (low), 8 data bits LSB first, optional even-parity bit, 1 stop bit (high).
- Oversamples `rx` at CLKS_PER_BIT clocks per bit and samples each bit at its midpoint.
- Presents each received byte with error flags through a one-entry valid/ready holding register.

Parameters:
- CLKS_PER_BIT, 16, clocks per serial bit; must be ≥ 4 and even.
- PARITY_EN, 1, 1 = frame carries an even-parity bit (parity bit = XOR of the 8 data bits); 0 = no parity bit.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- rx  input  1  serial line; asynchronous; idles high.
- data_out  output  8  received byte; stable while valid=1.
- valid  output  1  data_out/flags hold an unconsumed frame.
- ready  input  1  consumer accepts data_out when valid&&ready at a rising clk.
- parity_err  output  1  parity mismatch for the held frame; 0 when PARITY_EN=0.
- frame_err  output  1  stop bit sampled low for the held frame.
- overrun  output  1  one-cycle pulse: a completed frame was dropped because the holding register was full.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Synchronizer:
  - `rx` passes through a 2-flop synchronizer; both flops reset to 1.
  - All logic below uses the synchronized value rx_s.
- Reset values:
  - FSM in IDLE; counters and shift register 0.
  - data_out=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame; no valid is produced.
- Bit timing:
  - A clock counter runs 0..CLKS_PER_BIT-1.
  - Start-bit midpoint: counter == CLKS_PER_BIT/2-1 after start detection.
  - Every later sample: counter == CLKS_PER_BIT-1, i.e. one full bit period after the previous sample.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on rx_s==0, clear counter and go to START.
  - START: at the midpoint, if rx_s==1 treat it as a glitch and return to IDLE with no output; else clear counter, clear bit index, go to DATA.
  - DATA: at each sample, shift rx_s into bit 7 of the shift register, shifting right so that the first bit lands in bit 0 after 8 samples. After the 8th sample go to PARITY (PARITY_EN=1) or STOP (PARITY_EN=0).
  - PARITY: at the sample, capture perr = rx_s XOR (^shift). Go to STOP.
  - STOP: at the sample the frame completes; ferr = ~rx_s. If rx_s==1 go to IDLE, else go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE when rx_s==1. New start detection is blocked until then, so a break condition yields exactly one frame_err frame.
- Completion: the frame is delivered on the clock edge that samples the stop bit. valid, data_out and the flags are visible the following cycle.
  - Latency from the rx falling edge at the pin to valid: 2 + CLKS_PER_BIT/2 + (9 + PARITY_EN)·CLKS_PER_BIT cycles, ±1.
- Output handshake:
  - valid is held until valid&&ready; data_out, parity_err and frame_err stay constant while valid=1.
  - Completion while valid=0, or while valid&&ready in the same cycle: load the new frame; valid=1.
  - Completion while valid&&!ready: drop the new frame, keep the old contents, pulse overrun for 1 cycle.
  - On valid&&ready with no completion: valid goes to 0; data_out keeps its last value.
- Back-to-back frames: a start bit immediately following a good stop bit is accepted. The FSM is back in IDLE half a bit period before the stop bit ends.

Test Plan:
- CLKS_PER_BIT=16, PARITY_EN=1, ready=1; send 0xA5 with parity bit 0 → one valid pulse with data_out=0xA5, parity_err=0, frame_err=0. busy is high for the whole frame and low afterwards.
- Send 0x3C with parity bit 1 → data_out=0x3C, parity_err=1. Then send 0x01 with parity bit 1 → data_out=0x01, parity_err=0.
- Drive rx low for 4 clocks, then high → no valid. busy returns to 0 within CLKS_PER_BIT/2+3 cycles.
- Send 0x55 with stop bit 0, then hold rx low for 3 bit times → data_out=0x55, frame_err=1, exactly one valid. No new frame is received until rx returns high.
- ready=0; send 0x11 then 0x22 back-to-back → data_out stays 0x11, overrun pulses once at the 0x22 stop sample. Raising ready for 1 cycle then drops valid to 0.
- Assert rst during bit 4 of a frame → all outputs return to reset values immediately. After release, a clean 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even parity, one stop bit,
// midpoint sampling, one-entry valid/ready output register with overrun pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic          rx_meta_q, rx_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          perr_q, perr_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          perr_out_q, perr_out_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          done, ferr_new, half_hit, full_hit;

    // Line idles high, so both synchronizer stages reset to 1 to avoid a false start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign half_hit = (cnt_q == HALF_M1);
    assign full_hit = (cnt_q == FULL_M1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        done     = 1'b0;
        ferr_new = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (half_hit) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = 3'd0;
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (full_hit) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PARITY: begin
                if (full_hit) begin
                    cnt_d   = '0;
                    perr_d  = rx_s_q ^ (^shift_q);
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (full_hit) begin
                    cnt_d    = '0;
                    done     = 1'b1;
                    ferr_new = ~rx_s_q;
                    state_d  = rx_s_q ? S_IDLE : S_WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_HIGH: begin
                // A break holds the line low; re-arm only once it returns high.
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_d     = ferr_q;
        ovr_d      = 1'b0;
        if (done) begin
            if (!valid_q || ready) begin
                data_d     = shift_q;
                perr_out_d = (PARITY_EN != 0) ? perr_q : 1'b0;
                ferr_d     = ferr_new;
                valid_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            shift_q    <= 8'd0;
            perr_q     <= 1'b0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);

endmodule
